// File: rtl/prog_loader.sv
// prog_loader: loads a length-framed byte stream as 16-bit words into instruction memory.
// Define LOADER_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module prog_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        r_st,
    input  logic        load_req,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        iw_we,
    output logic [15:0] iw_addr,
    output logic [15:0] iw_data,
    output logic        cpu_start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_cnt
);
`ifdef LOADER_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, DONE, ERR} state_t;
`endif
    state_t      state;
    logic [7:0]  len_hi;
    logic [7:0]  hi;
    logic [15:0] len;
    logic        xfer;
    logic        arm;
    logic [15:0] len_in;
    assign xfer   = rx_valid && rx_ready;
    assign arm    = load_req && (state == IDLE || state == DONE || state == ERR);
    assign len_in = {len_hi, rx_data};
`ifdef LOADER_CHKSUM_EN
    logic [7:0] chk;
    always_ff @(posedge clk or negedge r_st) begin
        if (!r_st)
            chk <= '0;
        else if (arm)
            chk <= '0;
        else if (xfer && state != CHK)
            chk <= chk ^ rx_data;
    end
`endif
    // word_cnt doubles as the write index; it is cleared on every arm
    always_ff @(posedge clk or negedge r_st) begin
        if (!r_st) begin
            state     <= IDLE;
            rx_ready  <= 1'b0;
            iw_we     <= 1'b0;
            iw_addr   <= '0;
            iw_data   <= '0;
            cpu_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            word_cnt  <= '0;
            len_hi    <= '0;
            len       <= '0;
            hi        <= '0;
        end else begin
            cpu_start <= 1'b0;
            iw_we     <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (arm) begin
                    state    <= LEN_HI;
                    rx_ready <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    err      <= 1'b0;
                    word_cnt <= '0;
                end
                LEN_HI: if (xfer) begin
                    len_hi <= rx_data;
                    state  <= LEN_LO;
                end
                LEN_LO: if (xfer) begin
                    len <= len_in;
                    if (32'(len_in) > MAX_WORDS) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        busy     <= 1'b0;
                        rx_ready <= 1'b0;
                    end else if (len_in == 16'd0) begin
`ifdef LOADER_CHKSUM_EN
                        state <= CHK;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_start <= 1'b1;
                        rx_ready  <= 1'b0;
`endif
                    end else
                        state <= DATA_HI;
                end
                DATA_HI: if (xfer) begin
                    hi    <= rx_data;
                    state <= DATA_LO;
                end
                // a write cycle parks here with rx_ready low, then moves on
                DATA_LO: if (iw_we) begin
                    if (word_cnt < len) begin
                        state    <= DATA_HI;
                        rx_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHKSUM_EN
                        state    <= CHK;
                        rx_ready <= 1'b1;
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_start <= 1'b1;
`endif
                    end
                end else if (xfer) begin
                    iw_we    <= 1'b1;
                    iw_data  <= {hi, rx_data};
                    iw_addr  <= BASE_ADDR + word_cnt;
                    word_cnt <= word_cnt + 16'd1;
                    rx_ready <= 1'b0;
                end
`ifdef LOADER_CHKSUM_EN
                CHK: if (xfer) begin
                    rx_ready  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= (rx_data == chk) ? DONE : ERR;
                    done      <= (rx_data == chk);
                    err       <= (rx_data != chk);
                    cpu_start <= (rx_data == chk);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a queue-based scoreboard of expected writes and outcomes.
module tb_prog_loader;
    localparam logic [15:0] BASE = 16'hFFFF;
    localparam int          MAXW = 256;
    typedef logic [15:0] wq_t[$];

    logic        clk = 1'b0;
    logic        r_st = 1'b0;
    logic        load_req = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, iw_we, cpu_start, busy, done, err;
    logic [15:0] iw_addr, iw_data, word_cnt;

    prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .r_st(r_st), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .iw_we(iw_we), .iw_addr(iw_addr), .iw_data(iw_data),
        .cpu_start(cpu_start), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] wr_q[$];
    logic [16:0] end_q[$];
    logic [16:0] e_m;
    logic done_p = 1'b0;
    logic err_p = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        tests++;
        fails++;
        $display("FAIL %s: event occurred with nothing expected", name);
    endtask

    // monitor: pops expectations whenever the DUT writes or finishes a frame
    always @(negedge clk) begin
        if (r_st) begin
            if (iw_we) begin
                if (wr_q.size() == 0) fail("write");
                else check("write addr/data", {iw_addr, iw_data}, 64'(wr_q.pop_front()));
            end
            if ((done && !done_p) || (err && !err_p)) begin
                if (end_q.size() == 0) fail("frame end");
                else begin
                    e_m = end_q.pop_front();
                    check("end {start,done,err,busy,rdy,cnt}",
                          {cpu_start, done, err, busy, rx_ready, word_cnt},
                          {e_m[16], e_m[16], !e_m[16], 1'b0, 1'b0, e_m[15:0]});
                end
            end else if (cpu_start) fail("stray cpu_start");
        end
        done_p = done;
        err_p  = err;
    end

    task automatic arm();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // offers a byte until taken; stray load_req pulses mid-load must be ignored
    task automatic send(logic [7:0] b, int gap);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        load_req = ($urandom_range(0, 7) == 0);
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("rx_ready timeout", 0, 1);
            rx_valid = 1'b0;
            load_req = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        load_req = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("busy drops", 64'(busy), 0);
        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(wr_q.size() + end_q.size()), 0);
    endtask

    function automatic wq_t rnd(int k);
        wq_t q;
        for (int i = 0; i < k; i++) q.push_back(16'($urandom));
        return q;
    endfunction

    // reference model: expectations derived from the frame rules, pushed just before the final byte
    task automatic frame(logic [15:0] n, wq_t ws, int gap, bit bad);
        logic [7:0] c;
        c = n[15:8] ^ n[7:0];
        send(n[15:8], gap);
        if (n > MAXW) begin
            end_q.push_back({1'b0, 16'd0});
            send(n[7:0], gap);
        end else begin
`ifndef LOADER_CHKSUM_EN
            if (n == 0) end_q.push_back({1'b1, 16'd0});
`endif
            send(n[7:0], gap);
            for (int i = 0; i < int'(n); i++) begin
                c ^= ws[i][15:8] ^ ws[i][7:0];
                wr_q.push_back({BASE + 16'(i), ws[i]});
`ifndef LOADER_CHKSUM_EN
                if (i == int'(n) - 1) end_q.push_back({1'b1, n});
`endif
                send(ws[i][15:8], gap);
                send(ws[i][7:0], gap);
            end
`ifdef LOADER_CHKSUM_EN
            end_q.push_back({!bad, n});
            send(bad ? ~c : c, gap);
`endif
        end
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        wq_t ws;
        logic [15:0] n;
        repeat (3) @(negedge clk);
        check("reset outputs", {rx_ready, iw_we, iw_addr, iw_data, cpu_start, busy, done, err, word_cnt}, 0);
        r_st = 1'b1;
        @(negedge clk);
        check("idle rx_ready", 64'(rx_ready), 0);

        ws = '{16'h1234, 16'hABCD, 16'h0001};
        arm(); frame(16'd3, ws, 0, 1'b0);
        arm(); frame(16'd3, ws, 0, 1'b1);
        ws = {};
        arm(); frame(16'h0101, ws, 0, 1'b0);
        arm(); frame(16'd0, ws, 1, 1'b0);
        arm(); frame(16'd2, rnd(2), 5, 1'b0);

        // re-arm from DONE while a byte is offered: that byte must not be consumed
        load_req = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        @(negedge clk);
        load_req = 1'b0;
        rx_valid = 1'b0;
        check("re-arm busy", 64'(busy), 1);
        frame(16'd3, rnd(3), 0, 1'b0);

        // asynchronous reset while waiting for a DATA_LO byte
        ws = rnd(3);
        arm();
        send(8'h00, 0);
        send(8'h03, 0);
        wr_q.push_back({BASE, ws[0]});
        send(ws[0][15:8], 0);
        send(ws[0][7:0], 0);
        send(ws[1][15:8], 0);
        repeat (2) @(negedge clk);
        #2 r_st = 1'b0;
        #1 check("async reset outputs",
                 {rx_ready, iw_we, iw_addr, iw_data, cpu_start, busy, done, err, word_cnt}, 0);
        check("write before reset seen", 64'(wr_q.size()), 0);
        wr_q.delete();
        end_q.delete();
        @(negedge clk);
        r_st = 1'b1;
        @(negedge clk);
        arm(); frame(16'd2, rnd(2), 0, 1'b0);

        arm(); frame(16'(MAXW), rnd(MAXW), 0, 1'b0);

        for (int k = 0; k < 16; k++) begin
            n = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(MAXW + 1, 65535)) : 16'($urandom_range(0, 8));
            arm();
            frame(n, (n > MAXW) ? rnd(0) : rnd(int'(n)), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
